// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC fetch/sequence controller: FSM state codes
// (also driven on state_o for the board display), opcode values and field position.
package pc_seq_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_FETCH   = 3'd1;
   localparam logic [2:0] ST_DECODE  = 3'd2;
   localparam logic [2:0] ST_OPFETCH = 3'd3;
   localparam logic [2:0] ST_UPDATE  = 3'd4;
   localparam logic [2:0] ST_UPDATE2 = 3'd5;
   localparam logic [2:0] ST_HALT    = 3'd6;

   typedef enum logic [1:0] {
      OPC_NOP  = 2'b00,
      OPC_JMP  = 2'b01,
      OPC_SKIP = 2'b10,
      OPC_HALT = 2'b11
   } opcode_e;

   // Opcode field bit positions, counted down from the instruction MSB.
   localparam int OPC_MSB = 0;
   localparam int OPC_LSB = 1;

endpackage

// File: rtl/pc_seq_decode.sv
// Combinational opcode decoder for the PC sequence controller.
module pc_seq_decode
   import pc_seq_pkg::*;
(
   input  opcode_e opc,
   output logic    is_jmp,
   output logic    is_skip,
   output logic    is_halt
);

   assign is_jmp  = (opc == OPC_JMP);
   assign is_skip = (opc == OPC_SKIP);
   assign is_halt = (opc == OPC_HALT);

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch/sequence controller driving the PC load/inc/pc_in inputs from fetched opcodes.
// Optional breakpoint support is built when PC_SEQ_BREAKPOINT_EN is defined.
module pc_seq_ctrl
   import pc_seq_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic [ADDR_W-1:0] pc_cur,
   output logic              pc_load,
   output logic              pc_inc,
   output logic [ADDR_W-1:0] pc_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   output logic              halted,
   output logic [2:0]        state_o
`ifdef PC_SEQ_BREAKPOINT_EN
   ,
   input  logic              bp_en,
   input  logic [ADDR_W-1:0] bp_addr,
   output logic              bp_hit
`endif
);

   logic [2:0] state_q, state_d;
   logic       is_jmp, is_skip, is_halt;
   logic       enter_fetch;
   logic       fetch_go;
   logic       bp_stop;
   logic       bp_hold;

   pc_seq_decode u_decode (
      .opc     (opcode_e'(instr[DATA_W-1-OPC_MSB:DATA_W-1-OPC_LSB])),
      .is_jmp  (is_jmp),
      .is_skip (is_skip),
      .is_halt (is_halt)
   );

   // Points where the sequencer wants to start a new instruction fetch.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      enter_fetch = 1'b0;
      case (state_q)
         ST_IDLE:    enter_fetch = bp_hold ? (step && !run) : (run || step);
         ST_UPDATE:  enter_fetch = !is_skip && run;
         ST_UPDATE2: enter_fetch = run;
         default:    enter_fetch = 1'b0;
      endcase
   end

   assign fetch_go = enter_fetch && !bp_stop;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (fetch_go) state_d = ST_FETCH;
         ST_FETCH:   if (mem_ack) state_d = ST_DECODE;
         ST_DECODE: begin
            if (is_halt)     state_d = ST_HALT;
            else if (is_jmp) state_d = ST_OPFETCH;
            else             state_d = ST_UPDATE;
         end
         ST_OPFETCH: if (mem_ack) state_d = ST_UPDATE;
         ST_UPDATE: begin
            if (is_skip)       state_d = ST_UPDATE2;
            else if (fetch_go) state_d = ST_FETCH;
            else               state_d = ST_IDLE;
         end
         ST_UPDATE2: state_d = fetch_go ? ST_FETCH : ST_IDLE;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         instr       <= '0;
         instr_valid <= 1'b0;
         pc_target   <= '0;
      end else begin
         state_q     <= state_d;
         instr_valid <= (state_q == ST_FETCH) && mem_ack;
         if ((state_q == ST_FETCH) && mem_ack)
            instr <= mem_rdata;
         if ((state_q == ST_OPFETCH) && mem_ack)
            pc_target <= ADDR_W'(mem_rdata);
      end
   end

   // pc_cur only moves in UPDATE/UPDATE2, so the address is stable for a whole request.
   assign mem_req = (state_q == ST_FETCH) || (state_q == ST_OPFETCH);

   always_comb begin
      mem_addr = '0;
      if (state_q == ST_FETCH)
         mem_addr = pc_cur;
      else if (state_q == ST_OPFETCH)
         mem_addr = pc_cur + ADDR_W'(1);
   end

   assign pc_load = (state_q == ST_UPDATE) && is_jmp;
   assign pc_inc  = ((state_q == ST_UPDATE) && !is_jmp) || (state_q == ST_UPDATE2);
   assign halted  = (state_q == ST_HALT);
   assign state_o = state_q;

`ifdef PC_SEQ_BREAKPOINT_EN
   logic [ADDR_W-1:0] next_fetch_addr;
   logic              bp_check;

   // A stepped resume after a breakpoint is not checked again.
   always_comb begin
      next_fetch_addr = pc_cur;
      bp_check        = 1'b0;
      case (state_q)
         ST_IDLE:    bp_check = !bp_hold;
         ST_UPDATE: begin
            bp_check        = !is_skip;
            next_fetch_addr = is_jmp ? pc_target : pc_cur + ADDR_W'(1);
         end
         ST_UPDATE2: begin
            bp_check        = 1'b1;
            next_fetch_addr = pc_cur + ADDR_W'(1);
         end
         default:    bp_check = 1'b0;
      endcase
   end

   assign bp_stop = enter_fetch && bp_check && bp_en && (next_fetch_addr == bp_addr);

   always_ff @(posedge clk) begin
      if (reset) begin
         bp_hold <= 1'b0;
         bp_hit  <= 1'b0;
      end else begin
         bp_hit <= bp_stop;
         if (bp_stop)
            bp_hold <= 1'b1;
         else if ((state_q == ST_IDLE) && enter_fetch)
            bp_hold <= 1'b0;
      end
   end
`else
   assign bp_stop = 1'b0;
   assign bp_hold = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Self-checking bench for pc_seq_ctrl: PC register, wait-state memory and an
// instruction-level reference model. Breakpoint test builds with PC_SEQ_BREAKPOINT_EN.
module tb_pc_seq_ctrl;
   import pc_seq_pkg::*;

   typedef struct packed {
      logic       is_load;
      logic [7:0] target;
   } pulse_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       run = 1'b0;
   logic       step = 1'b0;
   logic [7:0] pc = 8'h00;
   logic       pc_load, pc_inc;
   logic [7:0] pc_target;
   logic       mem_req, mem_ack;
   logic [7:0] mem_addr, mem_rdata;
   logic [7:0] instr;
   logic       instr_valid, halted;
   logic [2:0] state_o;
`ifdef PC_SEQ_BREAKPOINT_EN
   logic       bp_en = 1'b0;
   logic [7:0] bp_addr = 8'h00;
   logic       bp_hit;
   int         bp_hits = 0;
`endif

   logic [7:0] mem [256];
   int         wait_cfg = 0;
   int         wcnt = 0;
   logic       pc_force = 1'b0;
   logic [7:0] pc_force_val = 8'h00;
   logic       chk_en = 1'b0;
   int         cyc = 0;

   int         n_cmp = 0;
   int         n_err = 0;

   logic [7:0] exp_addr  [$];
   logic [7:0] exp_instr [$];
   pulse_t     exp_pulse [$];
   logic [7:0] pc_log    [$];
   logic [7:0] addr_log  [$];
   int         instr_cyc [$];
   logic [7:0] last_target = 8'h00;
   logic [7:0] model_pc = 8'h00;
   logic [7:0] req_addr = 8'h00;
   logic       req_open = 1'b0;

   always #5 clk = ~clk;

   pc_seq_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
      .step        (step),
      .pc_cur      (pc),
      .pc_load     (pc_load),
      .pc_inc      (pc_inc),
      .pc_target   (pc_target),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_ack     (mem_ack),
      .mem_rdata   (mem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .halted      (halted),
      .state_o     (state_o)
`ifdef PC_SEQ_BREAKPOINT_EN
      ,
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .bp_hit      (bp_hit)
`endif
   );

   // Environment: the PC register and a memory answering after wait_cfg extra cycles.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (pc_force)     pc <= pc_force_val;
      else if (pc_load) pc <= pc_target;
      else if (pc_inc)  pc <= pc + 8'd1;
      if (reset || !mem_req || mem_ack) wcnt <= 0;
      else                              wcnt <= wcnt + 1;
   end

   assign mem_ack   = mem_req && (wcnt == wait_cfg);
   assign mem_rdata = mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Instruction-level model: walks the program and queues the fetch addresses,
   // opcode bytes and PC pulses the controller must produce, in order.
   task automatic model_run(input logic [7:0] start, input int max_instr);
      logic [7:0] p, b, nxt;
      p = start;
      for (int k = 0; k < max_instr; k++) begin
         b = mem[p];
         exp_addr.push_back(p);
         exp_instr.push_back(b);
         if (b[7:6] == 2'b11) break;
         if (b[7:6] == 2'b00) begin
            exp_pulse.push_back(pulse_t'{1'b0, 8'h00});
            p = p + 8'd1;
         end else if (b[7:6] == 2'b10) begin
            exp_pulse.push_back(pulse_t'{1'b0, 8'h00});
            exp_pulse.push_back(pulse_t'{1'b0, 8'h00});
            p = p + 8'd2;
         end else begin
            nxt = p + 8'd1;
            exp_addr.push_back(nxt);
            exp_pulse.push_back(pulse_t'{1'b1, mem[nxt]});
            p = mem[nxt];
         end
      end
      model_pc = p;
   endtask

   // Compare process: every cycle with checking enabled.
   always @(negedge clk) begin
      pulse_t e;
      if (!chk_en) begin
         req_open = 1'b0;
      end else begin
         check("pulse_exclusive", pc_load && pc_inc, 1'b0);
         if (pc_load || pc_inc) begin
            check("pulse_expected", exp_pulse.size() > 0, 1'b1);
            if (exp_pulse.size() > 0) begin
               e = exp_pulse.pop_front();
               check("pulse_kind_load", pc_load, e.is_load);
               if (e.is_load) check("pc_target", pc_target, e.target);
            end
            if (pc_load) last_target = pc_target;
         end
         if (instr_valid) begin
            check("instr_expected", exp_instr.size() > 0, 1'b1);
            if (exp_instr.size() > 0) check("instr", instr, exp_instr.pop_front());
            pc_log.push_back(pc);
            instr_cyc.push_back(cyc);
         end
         if (req_open) check("req_held_until_ack", mem_req, 1'b1);
         if (mem_req) begin
            if (req_open) begin
               check("addr_stable", mem_addr, req_addr);
            end else begin
               check("fetch_expected", exp_addr.size() > 0, 1'b1);
               if (exp_addr.size() > 0) check("fetch_addr", mem_addr, exp_addr.pop_front());
               req_addr = mem_addr;
               addr_log.push_back(mem_addr);
            end
            req_open = !mem_ack;
         end else begin
            req_open = 1'b0;
         end
`ifdef PC_SEQ_BREAKPOINT_EN
         if (bp_hit) bp_hits++;
`endif
      end
   end

   function automatic logic [31:0] all_outs();
      return {pc_load, pc_inc, pc_target, mem_req, mem_addr, instr, instr_valid, halted, state_o};
   endfunction

   task automatic do_reset(input logic [7:0] start_pc);
      @(negedge clk);
      chk_en = 1'b0; reset = 1'b1; run = 1'b0; step = 1'b0;
      pc_force = 1'b1; pc_force_val = start_pc;
      @(negedge clk);
      pc_force = 1'b0;
      @(negedge clk);
      check("reset_outputs_zero", all_outs(), 32'h0);
      reset = 1'b0;
      exp_addr.delete(); exp_instr.delete(); exp_pulse.delete();
      pc_log.delete(); addr_log.delete(); instr_cyc.delete();
      @(negedge clk);
      check("post_reset_idle_outputs", all_outs(), 32'h0);
      chk_en = 1'b1;
   endtask

   task automatic pulse_step();
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
   endtask

   task automatic wait_halt(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (halted) break;
         @(negedge clk);
      end
      check("wait_halted", halted, 1'b1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (state_o == ST_IDLE) break;
      end
      check(tag, state_o, ST_IDLE);
   endtask

   task automatic drained(input string tag);
      check({tag, "_pulses_left"}, exp_pulse.size(), 0);
      check({tag, "_instrs_left"}, exp_instr.size(), 0);
      check({tag, "_fetches_left"}, exp_addr.size(), 0);
   endtask

   task automatic load_main_program();
      for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
      mem[8'h00] = 8'h00;
      mem[8'h01] = 8'h80;
      mem[8'h02] = 8'hC0;
      mem[8'h03] = 8'h40;
      mem[8'h04] = 8'h10;
      mem[8'h10] = 8'hC0;
   endtask

   task automatic check_main_seq(input string tag);
      logic [7:0] seq_ref [4];
      seq_ref = '{8'h00, 8'h01, 8'h03, 8'h10};
      check({tag, "_pc_seq_len"}, pc_log.size(), 4);
      for (int i = 0; i < 4 && i < pc_log.size(); i++)
         check($sformatf("%s_pc_seq[%0d]", tag, i), pc_log[i], seq_ref[i]);
   endtask

   initial begin
      int len;

      // Free-run, zero-wait memory.
      load_main_program();
      wait_cfg = 0;
      do_reset(8'h00);
      model_run(8'h00, 10);
      check("model_final_pc", model_pc, 8'h10);
      run = 1'b1;
      wait_halt(200);
      check("run0_pc_at_halt", pc, 8'h10);
      check_main_seq("run0");
      if (instr_cyc.size() >= 3) begin
         check("nop_latency", instr_cyc[1] - instr_cyc[0], 3);
         check("skip_latency", instr_cyc[2] - instr_cyc[1], 4);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_sticky", halted, 1'b1);
         check("halt_pc_hold", pc, 8'h10);
      end
      drained("run0");

      // Free-run with a 3-cycle ack delay.
      wait_cfg = 3;
      do_reset(8'h00);
      model_run(8'h00, 10);
      run = 1'b1;
      for (int i = 0; i < 20 && !mem_req; i++) @(negedge clk);
      len = 0;
      for (int i = 0; i < 20 && mem_req; i++) begin
         len++;
         if (mem_ack) break;
         @(negedge clk);
      end
      check("wait3_req_cycles", len, 4);
      wait_halt(400);
      check("wait3_pc_at_halt", pc, 8'h10);
      check_main_seq("wait3");
      drained("wait3");

      // Step mode, with a step issued during a pending fetch.
      do_reset(8'h00);
      model_run(8'h00, 2);
      repeat (3) @(negedge clk);
      check("step_no_autostart", state_o, ST_IDLE);
      pulse_step();
      wait_idle("step1_idle", 50);
      check("step1_pc", pc, 8'h01);
      repeat (5) @(negedge clk);
      check("step1_still_idle", state_o, ST_IDLE);
      check("step1_pc_hold", pc, 8'h01);
      pulse_step();
      @(negedge clk);
      check("step2_fetch_pending", mem_req, 1'b1);
      pulse_step();
      wait_idle("step2_idle", 50);
      check("step2_pc", pc, 8'h03);
      repeat (10) @(negedge clk);
      check("step_ignored_pc", pc, 8'h03);
      check("step_ignored_idle", state_o, ST_IDLE);
      drained("step");

      // Reset during the JMP operand fetch.
      do_reset(8'h00);
      model_run(8'h00, 3);
      run = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (mem_req && mem_addr == 8'h04) break;
         @(negedge clk);
      end
      check("opfetch_reached", mem_addr, 8'h04);
      chk_en = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check("abort_mem_req", mem_req, 1'b0);
      check("abort_outputs_zero", all_outs(), 32'h0);
      check("abort_no_load_pc", pc, 8'h03);

      // Operand address wraps from 0xFF to 0x00.
      for (int i = 0; i < 256; i++) mem[i] = 8'hC0;
      mem[8'hFF] = 8'h40;
      mem[8'h00] = 8'h22;
      wait_cfg = 0;
      do_reset(8'hFF);
      model_run(8'hFF, 10);
      check("wrap_model_pc", model_pc, 8'h22);
      run = 1'b1;
      wait_halt(200);
      check("wrap_pc", pc, 8'h22);
      check("wrap_load_target", last_target, 8'h22);
      check("wrap_fetch_count", addr_log.size(), 3);
      if (addr_log.size() >= 3) begin
         check("wrap_fetch0", addr_log[0], 8'hFF);
         check("wrap_operand_addr", addr_log[1], 8'h00);
         check("wrap_fetch2", addr_log[2], 8'h22);
      end
      drained("wrap");

`ifdef PC_SEQ_BREAKPOINT_EN
      // Breakpoint at 0x03, then a single step through it.
      load_main_program();
      wait_cfg = 0;
      do_reset(8'h00);
      bp_en = 1'b1;
      bp_addr = 8'h03;
      bp_hits = 0;
      model_run(8'h00, 2);
      run = 1'b1;
      repeat (30) @(negedge clk);
      check("bp_stop_idle", state_o, ST_IDLE);
      check("bp_stop_pc", pc, 8'h03);
      check("bp_hit_count", bp_hits, 1);
      drained("bp_run");
      run = 1'b0;
      @(negedge clk);
      model_run(8'h03, 1);
      pulse_step();
      wait_idle("bp_step_idle", 50);
      check("bp_step_pc", pc, 8'h10);
      check("bp_hit_count_after_step", bp_hits, 1);
      drained("bp_step");
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
      $fatal(1, "watchdog expired");
   end

endmodule
